mb32_copy: RTL and testbench

MB32_COPY -- requirements
Module: mb32_copy

---
 rtl/mb32_copy.sv | 123 ++++++++++++
 tb/tb_mb32_copy.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mb32_copy.sv
// Word copy/fill DMA engine for the mb32 bus: COPY moves one word per
// RD/WR pair (2 cycles/word), FILL writes a pattern every cycle.
module mb32_copy #(
  parameter int AW = 15,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic          dir,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [31:0]   pat,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] remain,
  output logic [AW-1:0] ai,
  output logic [31:0]   vi,
  input  logic [31:0]   vo,
  output logic          we,
  output logic [3:0]    bmsk
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [31:0]   pat_q, pat_d;
  logic          dir_q, dir_d;
  // Last driven bus address/data, so IDLE and DONE keep the bus stable.
  logic [AW-1:0] ai_q;
  logic [31:0]   vi_q;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p, input logic d);
    return d ? p - AW'(1) : p + AW'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    pat_d   = pat_q;
    dir_d   = dir_q;
    ai      = ai_q;
    vi      = vi_q;
    we      = 1'b0;
    bmsk    = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d = len;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            src_d   = src;
            dst_d   = dst;
            pat_d   = pat;
            dir_d   = dir;
            state_d = op ? S_FILL : S_RD;
          end
        end
      end
      S_RD: begin
        ai      = src_q;
        state_d = abort ? S_DONE : S_WR;
      end
      S_WR: begin
        // Slave read data is registered, so vo now holds the RD-cycle word.
        ai      = dst_q;
        vi      = vo;
        we      = 1'b1;
        bmsk    = 4'hF;
        src_d   = nxt(src_q, dir_q);
        dst_d   = nxt(dst_q, dir_q);
        rem_d   = rem_q - LW'(1);
        state_d = (abort || rem_q == LW'(1)) ? S_DONE : S_RD;
      end
      S_FILL: begin
        ai      = dst_q;
        vi      = pat_q;
        we      = 1'b1;
        bmsk    = 4'hF;
        dst_d   = nxt(dst_q, dir_q);
        rem_d   = rem_q - LW'(1);
        state_d = (abort || rem_q == LW'(1)) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      dir_q   <= 1'b0;
      ai_q    <= '0;
      vi_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      dir_q   <= dir_d;
      ai_q    <= ai;
      vi_q    <= vi;
    end
  end

  assign busy   = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_FILL);
  assign done   = (state_q == S_DONE);
  assign remain = rem_q;

endmodule

// File: tb/tb_mb32_copy.sv
// Directed bench for mb32_copy with a registered-read 32K-word memory model.
module tb_mb32_copy;

  logic        clk = 1'b0;
  logic        rst, start, op, dir, abort;
  logic [14:0] src, dst;
  logic [15:0] len;
  logic [31:0] pat;
  logic        busy, done, we;
  logic [15:0] remain;
  logic [14:0] ai;
  logic [31:0] vi, vo;
  logic [3:0]  bmsk;

  logic [31:0] mem [0:32767];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  mb32_copy dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dir(dir),
    .src(src), .dst(dst), .len(len), .pat(pat), .abort(abort),
    .busy(busy), .done(done), .remain(remain),
    .ai(ai), .vi(vi), .vo(vo), .we(we), .bmsk(bmsk)
  );

  always #5 clk = ~clk;

  // Slave: write on we, read data registered one cycle after the address.
  always @(posedge clk) begin
    if (we) begin
      mem[ai] <= vi;
      wr_cnt  <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    vo <= mem[ai];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic o, input logic d, input logic [14:0] s,
                     input logic [14:0] t, input logic [15:0] l, input logic [31:0] p);
    start = 1'b1; op = o; dir = d; src = s; dst = t; len = l; pat = p;
    step();
    start = 1'b0;
  endtask

  int cnt;
  int w0, d0;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    vo = '0;
    rst = 1'b1; start = 1'b0; op = 1'b0; dir = 1'b0; abort = 1'b0;
    src = '0; dst = '0; len = '0; pat = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_remain", remain, 0);
    chk("rst_we", we, 0);
    chk("rst_bmsk", bmsk, 0);
    chk("rst_ai", ai, 0);
    chk("rst_vi", vi, 0);
    rst = 1'b0;
    step();

    // FILL 4 words at 0x0100, with a second start arriving mid-transfer
    cmd(1'b1, 1'b0, 15'h0, 15'h0100, 16'd4, 32'hDEADBEEF);
    chk("fill_busy1", busy, 1);
    chk("fill_we1", we, 1);
    chk("fill_bmsk1", bmsk, 4'hF);
    chk("fill_ai1", ai, 15'h0100);
    chk("fill_vi1", vi, 32'hDEADBEEF);
    chk("fill_rem1", remain, 4);
    start = 1'b1; op = 1'b1; dst = 15'h0500; len = 16'd2; pat = 32'h0BAD0BAD;
    step();
    start = 1'b0;
    chk("fill_ai2", ai, 15'h0101);
    chk("fill_rem2", remain, 3);
    step();
    chk("fill_ai3", ai, 15'h0102);
    step();
    chk("fill_ai4", ai, 15'h0103);
    chk("fill_busy4", busy, 1);
    step();
    chk("fill_done", done, 1);
    chk("fill_busy_off", busy, 0);
    chk("fill_we_off", we, 0);
    chk("fill_bmsk_off", bmsk, 0);
    chk("fill_ai_hold", ai, 15'h0103);
    chk("fill_vi_hold", vi, 32'hDEADBEEF);
    chk("fill_rem0", remain, 0);
    step();
    chk("fill_done_1cyc", done, 0);
    chk("fill_wr_cnt", wr_cnt, 4);
    for (int i = 0; i < 4; i++) chk("fill_mem", mem[15'h0100 + i], 32'hDEADBEEF);
    chk("ignored_start_mem", mem[15'h0500], 0);

    // Ascending COPY across 0x3FFF/0x4000
    for (int i = 0; i < 4; i++) mem[15'h3FFE + i] = 32'(i + 1);
    cmd(1'b0, 1'b0, 15'h3FFE, 15'h1000, 16'd4, 32'h0);
    chk("cpy_rd_ai", ai, 15'h3FFE);
    chk("cpy_rd_we", we, 0);
    step();
    chk("cpy_wr_ai", ai, 15'h1000);
    chk("cpy_wr_we", we, 1);
    chk("cpy_wr_vi", vi, 1);
    cnt = 2;
    step();
    for (int i = 0; i < 50 && !done; i++) begin
      if (busy) cnt++;
      step();
    end
    chk("cpy_done", done, 1);
    chk("cpy_busy_cycles", cnt, 8);
    for (int i = 0; i < 4; i++) chk("cpy_mem", mem[15'h1000 + i], i + 1);
    step();

    // Descending COPY with overlap (dst = src + 1)
    for (int i = 0; i < 4; i++) mem[15'h0200 + i] = 32'hA0 + i;
    mem[15'h0204] = 32'hFF;
    cmd(1'b0, 1'b1, 15'h0203, 15'h0204, 16'd4, 32'h0);
    for (int i = 0; i < 50 && !done; i++) step();
    chk("ovl_done", done, 1);
    for (int i = 0; i < 4; i++) chk("ovl_mem", mem[15'h0201 + i], 32'hA0 + i);
    chk("ovl_mem_below", mem[15'h0200], 32'hA0);
    step();

    // FILL wrapping through the top of the address space
    cmd(1'b1, 1'b0, 15'h0, 15'h7FFE, 16'd3, 32'h55AA55AA);
    chk("wrap_ai1", ai, 15'h7FFE);
    step();
    chk("wrap_ai2", ai, 15'h7FFF);
    step();
    chk("wrap_ai3", ai, 15'h0000);
    chk("wrap_we3", we, 1);
    step();
    chk("wrap_done", done, 1);
    chk("wrap_mem0", mem[0], 32'h55AA55AA);
    step();

    // len = 0: straight to DONE, no write
    w0 = wr_cnt;
    cmd(1'b1, 1'b0, 15'h0, 15'h0700, 16'd0, 32'h77777777);
    chk("len0_done", done, 1);
    chk("len0_we", we, 0);
    chk("len0_busy", busy, 0);
    step();
    chk("len0_done_off", done, 0);
    chk("len0_no_write", wr_cnt, w0);

    // Abort in RD of word 2 of a 5-word COPY
    for (int i = 0; i < 5; i++) begin
      mem[15'h0300 + i] = 32'h11 + i;
      mem[15'h0400 + i] = '0;
    end
    w0 = wr_cnt;
    cmd(1'b0, 1'b0, 15'h0300, 15'h0400, 16'd5, 32'h0);
    step();
    step();
    chk("abt_rd2_ai", ai, 15'h0301);
    chk("abt_rd2_we", we, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_done", done, 1);
    chk("abt_remain", remain, 4);
    chk("abt_we", we, 0);
    chk("abt_wr_cnt", wr_cnt - w0, 1);
    chk("abt_mem0", mem[15'h0400], 32'h11);
    chk("abt_mem1", mem[15'h0401], 0);
    step();

    // Reset in the middle of a FILL
    cmd(1'b1, 1'b0, 15'h0, 15'h0600, 16'd6, 32'h00001234);
    step();
    chk("rstf_ai", ai, 15'h0601);
    rst = 1'b1;
    step();
    w0 = wr_cnt;
    d0 = done_cnt;
    chk("rstf_busy", busy, 0);
    chk("rstf_done", done, 0);
    chk("rstf_remain", remain, 0);
    chk("rstf_we", we, 0);
    chk("rstf_bmsk", bmsk, 0);
    chk("rstf_ai0", ai, 0);
    chk("rstf_vi0", vi, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rstf_no_write", wr_cnt, w0);
    chk("rstf_no_done", done_cnt, d0);
    chk("rstf_mem_tail", mem[15'h0603], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
